// File: rtl/turbo_enc.sv
// turbo_enc: rate-1/3 turbo encoder built from two 8-state RSC encoders with
// trellis termination. The second encoder sees the message through the
// interleaver pi(i) = (P*i) mod K. The 3K+12-bit codeword leaves as four
// W-bit words, least-significant word first.
// Optional build macro ENC_ABORT_EN adds the abort_i input.
module turbo_enc #(
  parameter int unsigned K = 24,
  parameter int unsigned W = 21,
  parameter int unsigned P = 7
) (
  input  logic         clk_p_i,
  input  logic         reset_n_i,
  input  logic         start_i,
  input  logic [K-1:0] data_i,
`ifdef ENC_ABORT_EN
  input  logic         abort_i,
`endif
  output logic [W-1:0] data_o,
  output logic         valid_o,
  output logic         done_o,
  output logic         busy_o
);

  localparam int unsigned N  = 3*K + 12;
  localparam int unsigned CW = (K > 4) ? $clog2(K) : 3;

  typedef enum logic [1:0] {IDLE, ENC, TAIL, OUT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [CW-1:0]    pidx_q, pidx_d;
  logic [K-1:0]     msg_q, msg_d;
  logic [2:0]       enc1_q, enc1_d;   // {s1, s2, s3}
  logic [2:0]       enc2_q, enc2_d;
  logic [3*K-1:0]   body_q, body_d;
  logic [5:0]       tail1_q, tail1_d;
  logic [5:0]       tail2_q, tail2_d;
  logic [W-1:0]     data_q, data_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic             u1, u2, a1, a2, z1, z2;
  logic [CW:0]      psum;
  logic [CW-1:0]    pnext;
  logic [N-1:0]     cw;

  // Full codeword view: systematic/parity body, then encoder-1 and encoder-2 tails.
  assign cw = {tail2_q, tail1_q, body_q};

  // Encoder inputs, RSC recursion and incremental interleaver address.
  always_comb begin
    if (state_q == TAIL) begin
      u1 = enc1_q[1] ^ enc1_q[0];
      u2 = enc2_q[1] ^ enc2_q[0];
    end else begin
      u1 = msg_q[cnt_q];
      u2 = msg_q[pidx_q];
    end
    a1 = u1 ^ enc1_q[1] ^ enc1_q[0];
    z1 = a1 ^ enc1_q[2] ^ enc1_q[0];
    a2 = u2 ^ enc2_q[1] ^ enc2_q[0];
    z2 = a2 ^ enc2_q[2] ^ enc2_q[0];
    psum = {1'b0, pidx_q} + (CW+1)'(P);
    if (psum >= (CW+1)'(K)) begin
      pnext = CW'(psum - (CW+1)'(K));
    end else begin
      pnext = psum[CW-1:0];
    end
  end

  // Next-state logic: sequencing, codeword assembly and output word selection.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pidx_d  = pidx_q;
    msg_d   = msg_q;
    enc1_d  = enc1_q;
    enc2_d  = enc2_q;
    body_d  = body_q;
    tail1_d = tail1_q;
    tail2_d = tail2_q;
    data_d  = '0;
    valid_d = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = ENC;
          msg_d   = data_i;
          enc1_d  = '0;
          enc2_d  = '0;
          cnt_d   = '0;
          pidx_d  = '0;
        end
      end
      ENC: begin
        // Body is a right shift register: after K steps step 0 sits at bits [2:0].
        body_d = {z2, z1, u1, body_q[3*K-1:3]};
        enc1_d = {a1, enc1_q[2:1]};
        enc2_d = {a2, enc2_q[2:1]};
        pidx_d = pnext;
        if (cnt_q == CW'(K-1)) begin
          cnt_d   = '0;
          state_d = TAIL;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      TAIL: begin
        // Tail pairs shift in from the top so t=0 ends at bits [1:0] (x at bit 0).
        tail1_d = {z1, u1, tail1_q[5:2]};
        tail2_d = {z2, u2, tail2_q[5:2]};
        enc1_d  = {a1, enc1_q[2:1]};
        enc2_d  = {a2, enc2_q[2:1]};
        if (cnt_q == CW'(2)) begin
          cnt_d   = '0;
          state_d = OUT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      OUT: begin
        // The codeword store is shifted down one word per cycle as it is emitted.
        data_d  = cw[W-1:0];
        valid_d = 1'b1;
        done_d  = (cnt_q == CW'(3));
        {tail2_d, tail1_d, body_d} = cw >> W;
        if (cnt_q == CW'(3)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef ENC_ABORT_EN
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      data_d  = '0;
      valid_d = 1'b0;
      done_d  = 1'b0;
    end
`endif
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk_p_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pidx_q  <= '0;
      msg_q   <= '0;
      enc1_q  <= '0;
      enc2_q  <= '0;
      body_q  <= '0;
      tail1_q <= '0;
      tail2_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pidx_q  <= pidx_d;
      msg_q   <= msg_d;
      enc1_q  <= enc1_d;
      enc2_q  <= enc2_d;
      body_q  <= body_d;
      tail1_q <= tail1_d;
      tail2_q <= tail2_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign done_o  = done_q;
  assign busy_o  = (state_q != IDLE);

endmodule

// File: tb/tb_turbo_enc.sv
// tb_turbo_enc: directed, table-driven bench for turbo_enc plus multi-cycle
// sequences (back-to-back starts, ignored start, async reset, optional abort).
`timescale 1ns/1ps
module tb_turbo_enc;

  localparam int K = 24;
  localparam int W = 21;
  localparam int P = 7;
  localparam int N = 3*K + 12;

  typedef struct {
    logic [K-1:0] data;
    logic [N-1:0] exp;
  } vec_t;

  logic         clk_p_i = 1'b0;
  logic         reset_n_i = 1'b0;
  logic         start_i = 1'b0;
  logic [K-1:0] data_i = '0;
`ifdef ENC_ABORT_EN
  logic         abort_i = 1'b0;
`endif
  logic [W-1:0] data_o;
  logic         valid_o;
  logic         done_o;
  logic         busy_o;

  int tests = 0;
  int fails = 0;

  always #5 clk_p_i = ~clk_p_i;

  turbo_enc #(.K(K), .W(W), .P(P)) dut (
    .clk_p_i   (clk_p_i),
    .reset_n_i (reset_n_i),
    .start_i   (start_i),
    .data_i    (data_i),
`ifdef ENC_ABORT_EN
    .abort_i   (abort_i),
`endif
    .data_o    (data_o),
    .valid_o   (valid_o),
    .done_o    (done_o),
    .busy_o    (busy_o)
  );

  // Reference codeword: direct bit placement, interleaver by multiplication.
  function automatic logic [N-1:0] model(input logic [K-1:0] m);
    logic [N-1:0] c;
    logic [2:0]   s;
    logic [2:0]   t;
    logic         u, v, a, b, z, y;
    c = '0;
    s = '0;
    t = '0;
    for (int i = 0; i < K; i++) begin
      u = m[i];
      v = m[(P*i) % K];
      a = u ^ s[1] ^ s[0];
      z = a ^ s[2] ^ s[0];
      s = {a, s[2], s[1]};
      b = v ^ t[1] ^ t[0];
      y = b ^ t[2] ^ t[0];
      t = {b, t[2], t[1]};
      c[3*i]   = u;
      c[3*i+1] = z;
      c[3*i+2] = y;
    end
    for (int j = 0; j < 3; j++) begin
      u = s[1] ^ s[0];
      z = s[2] ^ s[0];
      s = {1'b0, s[2], s[1]};
      v = t[1] ^ t[0];
      y = t[2] ^ t[0];
      t = {1'b0, t[2], t[1]};
      c[3*K+2*j]   = u;
      c[3*K+2*j+1] = z;
      c[3*K+6+2*j] = v;
      c[3*K+7+2*j] = y;
    end
    return c;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_p_i);
    #1;
  endtask

  task automatic start_job(input logic [K-1:0] d);
    data_i  = d;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    chk("busy_after_start", N'(busy_o), N'(1));
  endtask

  // Called just after the accepting edge plus 'elapsed' further edges.
  task automatic collect(input logic [N-1:0] exp, input int elapsed, input string name);
    int           n;
    logic [N-1:0] got;
    n   = elapsed;
    got = '0;
    while (!valid_o && n < 40) begin
      tick();
      n++;
    end
    chk({name, "_latency"}, N'(n), N'(K+4));
    for (int w = 0; w < 4; w++) begin
      if (w > 0) tick();
      chk({name, "_valid"}, N'(valid_o), N'(1));
      chk({name, "_done"}, N'(done_o), N'(w == 3));
      if (w < 3) chk({name, "_busy"}, N'(busy_o), N'(1));
      got[w*W +: W] = data_o;
    end
    chk({name, "_codeword"}, got, exp);
  endtask

  task automatic post_job(input string name);
    tick();
    chk({name, "_post_valid"}, N'(valid_o), N'(0));
    chk({name, "_post_done"}, N'(done_o), N'(0));
    chk({name, "_post_data"}, N'(data_o), N'(0));
    chk({name, "_post_busy"}, N'(busy_o), N'(0));
  endtask

  task automatic quiet(input int cycles, input string name);
    int hits;
    hits = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (valid_o) hits++;
    end
    chk({name, "_no_valid"}, N'(hits), N'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs [6];
    logic [K-1:0] bb [8];
    logic [K-1:0] ma, mb;
    int           n;

    vecs[0] = '{24'h000000, '0};
    vecs[1] = '{24'h000001, {21'h1AEBB0, 21'h180DB0, 21'h180DB0, 21'h180DB7}};
    vecs[2] = '{24'hFFFFFF, model(24'hFFFFFF)};
    vecs[3] = '{24'h800000, model(24'h800000)};
    vecs[4] = '{24'hA5A5A5, model(24'hA5A5A5)};
    vecs[5] = '{24'h123456, model(24'h123456)};

    // Reset state
    #2;
    chk("rst_valid", N'(valid_o), N'(0));
    chk("rst_done", N'(done_o), N'(0));
    chk("rst_data", N'(data_o), N'(0));
    chk("rst_busy", N'(busy_o), N'(0));
    repeat (3) @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b1;
    tick();

    // Directed vectors
    for (int i = 0; i < 6; i++) begin
      start_job(vecs[i].data);
      collect(vecs[i].exp, 0, $sformatf("vec%0d", i));
      post_job($sformatf("vec%0d", i));
    end

    // Back-to-back with start held high: next accept one edge after word 3
    for (int j = 0; j < 8; j++) bb[j] = K'($urandom);
    data_i  = bb[0];
    start_i = 1'b1;
    tick();
    for (int j = 0; j < 8; j++) begin
      collect(model(bb[j]), 0, $sformatf("b2b%0d", j));
      if (j < 7) begin
        data_i = bb[j+1];
        tick();
        chk($sformatf("b2b%0d_spacing", j), N'(busy_o), N'(1));
      end else begin
        start_i = 1'b0;
        post_job("b2b_end");
      end
    end

    // Start during ENC is ignored
    ma = 24'h5A0F33;
    mb = 24'h0C0FFE;
    start_job(ma);
    repeat (4) tick();
    data_i  = mb;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    collect(model(ma), 5, "ignored_start");
    post_job("ignored_start");

    // Asynchronous reset while word 1 is on the output
    start_job(24'h3C3C3C);
    n = 0;
    while (!valid_o && n < 40) begin
      tick();
      n++;
    end
    tick();
    #2;
    reset_n_i = 1'b0;
    #1;
    chk("async_rst_valid", N'(valid_o), N'(0));
    chk("async_rst_done", N'(done_o), N'(0));
    chk("async_rst_data", N'(data_o), N'(0));
    chk("async_rst_busy", N'(busy_o), N'(0));
    repeat (2) @(posedge clk_p_i);
    #1;
    reset_n_i = 1'b1;
    quiet(35, "after_reset");
    start_job(24'hC0FFEE);
    collect(model(24'hC0FFEE), 0, "after_reset_job");
    post_job("after_reset_job");

`ifdef ENC_ABORT_EN
    // Abort during TAIL
    start_job(24'h777777);
    repeat (25) tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    chk("abort_tail_busy", N'(busy_o), N'(0));
    quiet(40, "abort_tail");
    // Abort and start together in ENC: abort wins
    start_job(24'h111111);
    repeat (3) tick();
    abort_i = 1'b1;
    start_i = 1'b1;
    data_i  = 24'h222222;
    tick();
    abort_i = 1'b0;
    start_i = 1'b0;
    chk("abort_wins_busy", N'(busy_o), N'(0));
    chk("abort_wins_valid", N'(valid_o), N'(0));
    start_job(24'hABCDEF);
    collect(model(24'hABCDEF), 0, "after_abort");
    post_job("after_abort");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
